// File: rtl/cpu_pkg.sv
// Shared CPU definitions: 2-bit branch counter states, PC increment and saturating helpers.
package cpu_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Step toward strongly-taken, holding at ST.
  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == ST) ? ST : ctr_t'(2'(c + 2'd1));
  endfunction

  // Step toward strongly-not-taken, holding at SNT.
  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == SNT) ? SNT : ctr_t'(2'(c - 2'd1));
  endfunction

endpackage

// File: rtl/btb_ram.sv
// Direct-mapped BTB storage: two async read ports and one sync write port with sync clear.
module btb_ram
  import cpu_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned TAG_W   = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_a_idx,
  output logic             rd_a_valid,
  output logic [TAG_W-1:0] rd_a_tag,
  output logic [PC_W-1:0]  rd_a_target,
  output ctr_t             rd_a_ctr,
  input  logic [IDX_W-1:0] rd_b_idx,
  output logic             rd_b_valid,
  output logic [TAG_W-1:0] rd_b_tag,
  output logic [PC_W-1:0]  rd_b_target,
  output ctr_t             rd_b_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [PC_W-1:0]  wr_target,
  input  ctr_t             wr_ctr
);

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [PC_W-1:0]  target_d [ENTRIES];
  ctr_t             ctr_q    [ENTRIES];
  ctr_t             ctr_d    [ENTRIES];

  // Read ports see pre-edge contents, so same-cycle writes appear next cycle.
  always_comb begin
    rd_a_valid  = valid_q[rd_a_idx];
    rd_a_tag    = tag_q[rd_a_idx];
    rd_a_target = target_q[rd_a_idx];
    rd_a_ctr    = ctr_q[rd_a_idx];
    rd_b_valid  = valid_q[rd_b_idx];
    rd_b_tag    = tag_q[rd_b_idx];
    rd_b_target = target_q[rd_b_idx];
    rd_b_ctr    = ctr_q[rd_b_idx];
  end

  // Next-state: hold everything, overwrite the single written entry.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (wr_en) begin
      valid_d[wr_idx]  = 1'b1;
      tag_d[wr_idx]    = wr_tag;
      target_d[wr_idx] = wr_target;
      ctr_d[wr_idx]    = wr_ctr;
    end
  end

  // Storage registers; reset invalidates all entries and parks counters at WNT.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WNT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side BTB predictor with EX-stage mispredict resolution, training and statistics.
module branch_predictor
  import cpu_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;

  logic             a_valid, b_valid;
  logic [TAG_W-1:0] a_tag, b_tag;
  logic [PC_W-1:0]  a_target, b_target;
  ctr_t             a_ctr, b_ctr;

  logic             res, miss, ex_hit, train;
  logic             wr_en;
  logic [PC_W-1:0]  wr_target;
  ctr_t             wr_ctr;

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];

  btb_ram #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .rd_a_idx    (if_idx),
    .rd_a_valid  (a_valid),
    .rd_a_tag    (a_tag),
    .rd_a_target (a_target),
    .rd_a_ctr    (a_ctr),
    .rd_b_idx    (ex_idx),
    .rd_b_valid  (b_valid),
    .rd_b_tag    (b_tag),
    .rd_b_target (b_target),
    .rd_b_ctr    (b_ctr),
    .wr_en       (wr_en),
    .wr_idx      (ex_idx),
    .wr_tag      (ex_tag),
    .wr_target   (wr_target),
    .wr_ctr      (wr_ctr)
  );

  // Zero-latency prediction for the fetch PC.
  always_comb begin
    pred_taken  = a_valid && (a_tag == if_tag) && a_ctr[1];
    pred_target = pred_taken ? a_target : if_pc + PC_INC;
  end

  // Mispredict detection and redirect; deliberately not gated by halt.
  always_comb begin
    res         = ex_valid && ex_branch;
    miss        = res && ((ex_taken != ex_pred_taken) ||
                          (ex_taken && (ex_target != ex_pred_target)));
    flush       = miss;
    redirect_pc = '0;
    if (miss) redirect_pc = ex_taken ? ex_target : ex_pc + PC_INC;
  end

  // BTB training: update counter on hit, allocate at WT on a taken tag miss.
  always_comb begin
    train     = res && !halt;
    ex_hit    = b_valid && (b_tag == ex_tag);
    wr_en     = 1'b0;
    wr_target = b_target;
    wr_ctr    = b_ctr;
    if (train) begin
      if (ex_hit) begin
        wr_en = 1'b1;
        if (ex_taken) begin
          wr_ctr    = sat_inc(b_ctr);
          wr_target = ex_target;
        end else begin
          wr_ctr = sat_dec(b_ctr);
        end
      end else if (ex_taken) begin
        wr_en     = 1'b1;
        wr_ctr    = WT;
        wr_target = ex_target;
      end
    end
  end

  // Saturating statistics counters.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (train) begin
      if (branch_cnt_q != {CNT_W{1'b1}}) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (miss && (miss_cnt_q != {CNT_W{1'b1}})) miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule
